// File: rtl/dct_pkg.sv
// Shared constants for the 8x8 Q16.16 DCT: cosine table, fixed-point
// parameters and the round/saturate step applied after each 1-D pass.
package dct_pkg;

    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = 67;

    localparam logic signed [ACC_W-1:0] ROUND_CONST =
        ACC_W'(1 << (FRAC_BITS - 1));

    // round(65536 * C(u)/2 * cos(k*pi/16)), C(0) folded into C4
    localparam logic signed [31:0] C1 = 32'sd32138;
    localparam logic signed [31:0] C2 = 32'sd30274;
    localparam logic signed [31:0] C3 = 32'sd27246;
    localparam logic signed [31:0] C4 = 32'sd23170;
    localparam logic signed [31:0] C5 = 32'sd18205;
    localparam logic signed [31:0] C6 = 32'sd12540;
    localparam logic signed [31:0] C7 = 32'sd6393;

    localparam logic signed [31:0] COS_TBL [8][8] = '{
        '{ C4,  C4,  C4,  C4,  C4,  C4,  C4,  C4},
        '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
        '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
        '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
        '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
        '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
        '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
        '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
    };

    function automatic logic [31:0] round_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] r;
        r = (acc + ROUND_CONST) >>> FRAC_BITS;
        if (r[ACC_W-1:31] == '0 || r[ACC_W-1:31] == '1) begin
            return r[31:0];
        end
        return r[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

endpackage

// File: rtl/dct_1d_8.sv
// Combinational 8-point DCT-II on Q16.16 samples, rounded and
// saturated back to 32 bits.
module dct_1d_8
    import dct_pkg::*;
(
    input  logic [7:0][31:0] x_i,
    output logic [7:0][31:0] y_o
);

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic signed [63:0]      prod;
        y_o  = '0;
        acc  = '0;
        prod = '0;
        for (int u = 0; u < 8; u++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) begin
                prod = 64'($signed(x_i[k])) * 64'(COS_TBL[u][k]);
                acc  = acc + ACC_W'(prod);
            end
            y_o[u] = round_sat(acc);
        end
    end

endmodule

// File: rtl/dct_2d_8x8.sv
// Three-stage pipelined 8x8 2-D DCT: input bank, row-DCT bank,
// column-DCT bank driving the output.
module dct_2d_8x8
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_in_matrix,
    output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_out_matrix
);

    localparam int N = DATA_DEPTH;
    localparam int W = DATA_WIDTH;

    // Indexed [row][col]; flat element row*N+col lines up with the ports.
    logic [N-1:0][N-1:0][W-1:0] in_q;
    logic [N-1:0][N-1:0][W-1:0] row_d, row_q;
    logic [N-1:0][N-1:0][W-1:0] row_t, colt_d;
    logic [N-1:0][N-1:0][W-1:0] col_d, out_q;

    for (genvar r = 0; r < N; r++) begin : g_dct
        dct_1d_8 u_row (
            .x_i(in_q[r]),
            .y_o(row_d[r])
        );
        dct_1d_8 u_col (
            .x_i(row_t[r]),
            .y_o(colt_d[r])
        );
    end

    always_comb begin
        row_t = '0;
        col_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                row_t[i][j] = row_q[j][i];
                col_d[i][j] = colt_d[j][i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q  <= '0;
            row_q <= '0;
            out_q <= '0;
        end else begin
            in_q  <= data_in_matrix;
            row_q <= row_d;
            out_q <= col_d;
        end
    end

    assign data_out_matrix = out_q;

endmodule

// File: tb/tb_dct_2d_8x8.sv
// Directed and randomised checks of dct_2d_8x8 against a real-valued
// 2-D DCT-II reference.
module tb_dct_2d_8x8;

    localparam int    TOL = 32'h8000;
    localparam real   PI  = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2047:0] din;
    logic [2047:0] dout;

    int  n_chk  = 0;
    int  n_pass = 0;
    real cs [8][8];
    int  exp_h [4][64];

    dct_2d_8x8 dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in_matrix (din),
        .data_out_matrix(dout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: no summary after 1 ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp, input int tol);
        longint d;
        n_chk++;
        d = longint'($signed(got)) - longint'($signed(exp));
        if (d < 0) d = -d;
        if (d > longint'(tol))
            $display("FAIL %s: got %08h expected %08h (tol %0h)",
                     tag, got, exp, tol);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] el(input int i);
        return dout[i*32 +: 32];
    endfunction

    task automatic model(input logic [2047:0] b, input int slot);
        real xin [8][8];
        real tmp [8][8];
        real acc;
        for (int i = 0; i < 64; i++)
            xin[i/8][i%8] = $itor($signed(b[i*32 +: 32])) / 65536.0;
        for (int x = 0; x < 8; x++)
            for (int v = 0; v < 8; v++) begin
                acc = 0.0;
                for (int y = 0; y < 8; y++) acc += xin[x][y] * cs[v][y];
                tmp[x][v] = acc;
            end
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                acc = 0.0;
                for (int x = 0; x < 8; x++) acc += cs[u][x] * tmp[x][v];
                acc = acc * 65536.0;
                acc = (acc >= 0.0) ? acc + 0.5 : acc - 0.5;
                if (acc > 2147483647.0) acc = 2147483647.0;
                if (acc < -2147483648.0) acc = -2147483648.0;
                exp_h[slot][u*8+v] = $rtoi(acc);
            end
    endtask

    task automatic chk_blk(input string tag, input int slot);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s[%0d]", tag, i), el(i), exp_h[slot][i], TOL);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s[%0d]", tag, i), el(i), 32'h0, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2047:0] gen(input int mode, input int i);
        logic [2047:0] b;
        int            e;
        b = '0;
        for (int j = 0; j < 64; j++) begin
            case (mode)
                0: begin
                    e = (i + 1) * (j + 1) * 32'h1000;
                    if (i % 2 == 1) e = -e;
                end
                1: e = int'($urandom_range(0, 255 * 65536));
                default:
                    e = int'($urandom_range(0, 32'h2000_0000))
                        - 32'sh1000_0000;
            endcase
            b[j*32 +: 32] = e;
        end
        return b;
    endfunction

    task automatic stream(input string tag, input int mode,
                          input int nblk);
        for (int i = 0; i < nblk + 2; i++) begin
            @(negedge clk);
            if (i < nblk) begin
                din = gen(mode, i);
                model(din, i % 4);
            end
            @(posedge clk);
            #1;
            if (i >= 2) chk_blk($sformatf("%s%0d", tag, i - 2), (i - 2) % 4);
        end
    endtask

    logic [2047:0] blk;

    initial begin
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++)
                cs[u][x] = ((u == 0) ? $sqrt(0.5) : 1.0) * 0.5
                           * $cos((2 * x + 1) * u * PI / 16.0);

        reset_n = 1'b1;
        din     = '0;
        #1 reset_n = 1'b0;
        #1 chk_zero("rst");

        din = gen(2, 0);
        step(2);
        chk_zero("rst_hold");

        @(negedge clk);
        din     = '0;
        reset_n = 1'b1;
        step(3);
        chk_zero("zero");

        blk = '0;
        for (int i = 0; i < 64; i++) blk[i*32 +: 32] = 32'h0001_0000;
        @(negedge clk);
        din = blk;
        step(3);
        chk("dc[0]", el(0), 32'h0008_0000, TOL);
        for (int i = 1; i < 64; i++)
            chk($sformatf("dc[%0d]", i), el(i), 32'h0, TOL);

        blk = '0;
        blk[31:0] = 32'h0008_0000;
        model(blk, 0);
        @(negedge clk);
        din = blk;
        step(2);
        chk("lat2", el(0), 32'h0008_0000, TOL);
        step(1);
        chk("imp0", el(0), 32'h0001_0000, TOL);
        chk_blk("imp", 0);

        stream("b2b", 0, 6);

        blk = gen(0, 2);
        model(blk, 0);
        @(negedge clk);
        din = blk;
        step(3);
        chk_blk("pre_rst", 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_async");
        step(2);
        chk_zero("rst_low");
        @(negedge clk);
        reset_n = 1'b1;
        step(2);
        chk_zero("rst_part");
        step(1);
        chk_blk("post_rst", 0);

        stream("rs", 1, 500);
        stream("rl", 2, 500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
